// File: rtl/refresh_scheduler_pkg.sv
// Shared types and defaults for the DDR3 refresh scheduler.
//   refresh_state_t : scheduler FSM states
//   DEF_*           : default timing in controller clocks (400 MHz)
//   cnt_width()     : down-counter width for a given cycle count (min 1)
package refresh_scheduler_pkg;

  localparam int unsigned DEF_CYCLE_TREFI  = 3120;  // 7.8 us
  localparam int unsigned DEF_CYCLE_TRFC   = 64;
  localparam int unsigned DEF_MAX_POSTPONE = 8;
  localparam int unsigned DEF_BANK_NUM     = 8;

  typedef enum logic [1:0] {
    S_INIT,
    S_RUN,
    S_GRANT,
    S_TRFC
  } refresh_state_t;

  function automatic int unsigned cnt_width(input int unsigned cycles);
    return (cycles > 1) ? $clog2(cycles) : 1;
  endfunction

endpackage

// File: rtl/refresh_scheduler_if.sv
// Refresh handshake between the scheduler, the main FSM and the tP_counters.
//   master : main-FSM side (drives init_done, bank_idle, ref_gnt, ref_issue)
//   slave  : scheduler side (drives refresh_flag, ref_req, ref_urgent,
//            ref_busy, pending_cnt, err_overflow, err_protocol)
interface refresh_scheduler_if #(
  parameter int unsigned BANK_NUM     = 8,
  parameter int unsigned MAX_POSTPONE = 8
);

  localparam int unsigned PW = $clog2(MAX_POSTPONE + 1);

  logic                init_done;
  logic [BANK_NUM-1:0] bank_idle;
  logic                ref_gnt;
  logic                ref_issue;
  logic                refresh_flag;
  logic                ref_req;
  logic                ref_urgent;
  logic                ref_busy;
  logic [PW-1:0]       pending_cnt;
  logic                err_overflow;
  logic                err_protocol;

  modport master (
    output init_done, bank_idle, ref_gnt, ref_issue,
    input  refresh_flag, ref_req, ref_urgent, ref_busy,
           pending_cnt, err_overflow, err_protocol
  );

  modport slave (
    input  init_done, bank_idle, ref_gnt, ref_issue,
    output refresh_flag, ref_req, ref_urgent, ref_busy,
           pending_cnt, err_overflow, err_protocol
  );

endinterface

// File: rtl/refresh_scheduler_timing_down_counter.sv
// Reusable loadable down-counter for DRAM timing windows.
//   clk, rst : controller clock, synchronous active-high reset (to RST_VAL)
//   load     : load 'value' (has priority over en)
//   value    : load value
//   en       : decrement enable; holds at zero
//   zero     : count is zero
module timing_down_counter #(
  parameter int unsigned    W       = 8,
  parameter logic [W-1:0]   RST_VAL = '0
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load,
  input  logic [W-1:0] value,
  input  logic         en,
  output logic         zero
);

  logic [W-1:0] cnt;

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt <= RST_VAL;
    end else if (load) begin
      cnt <= value;
    end else if (en && (cnt != '0)) begin
      cnt <= cnt - W'(1);
    end
  end

  assign zero = (cnt == '0);

endmodule

// File: rtl/refresh_scheduler.sv
// DDR3 auto-refresh demand generator for the global controller.
//   clk, rst : controller clock, synchronous active-high reset
//   bus      : refresh_scheduler_if slave port
//     init_done    - DRAM init complete; scheduler held in S_INIT while low
//     bank_idle    - per-bank idle/precharged
//     ref_gnt      - main FSM accepts refresh slot (pulse)
//     ref_issue    - REF issued on the DRAM bus (pulse)
//     refresh_flag - refresh sequence in progress (to tP_counters)
//     ref_req      - refresh slot request
//     ref_urgent   - postponement limit nearly reached
//     ref_busy     - tRFC window active
//     pending_cnt  - owed refreshes
//     err_overflow - sticky: tREFI tick while pending saturated
//     err_protocol - sticky: grant/issue outside the legal state
module refresh_scheduler
  import refresh_scheduler_pkg::*;
#(
  parameter int unsigned CYCLE_TREFI  = DEF_CYCLE_TREFI,
  parameter int unsigned CYCLE_TRFC   = DEF_CYCLE_TRFC,
  parameter int unsigned MAX_POSTPONE = DEF_MAX_POSTPONE,
  parameter int unsigned BANK_NUM     = DEF_BANK_NUM
) (
  input  logic          clk,
  input  logic          rst,
  refresh_scheduler_if.slave bus
);

  localparam int unsigned TW = cnt_width(CYCLE_TREFI);
  localparam int unsigned RW = cnt_width(CYCLE_TRFC);
  localparam int unsigned PW = $clog2(MAX_POSTPONE + 1);

  localparam logic [TW-1:0] TREFI_LOAD = TW'(CYCLE_TREFI - 1);
  localparam logic [RW-1:0] TRFC_LOAD  = RW'(CYCLE_TRFC - 1);
  localparam logic [PW-1:0] PEND_MAX   = PW'(MAX_POSTPONE);
  localparam logic [PW-1:0] PEND_URG   = PW'(MAX_POSTPONE - 1);

  refresh_state_t state, state_nxt;

  logic [PW-1:0] pending;
  logic          err_ovf_q, err_prot_q;
  logic          trefi_run, trefi_zero, trefi_load, tick;
  logic          trfc_zero;
  logic          urgent, req, flag, busy;
  logic          gnt_ok, issue_ok;

  // tREFI timer: frozen and held at reload value whenever not running
  assign trefi_run  = bus.init_done && (state != S_INIT);
  assign tick       = trefi_run && trefi_zero;
  assign trefi_load = tick || !trefi_run;

  timing_down_counter #(
    .W       (TW),
    .RST_VAL (TREFI_LOAD)
  ) u_trefi (
    .clk   (clk),
    .rst   (rst),
    .load  (trefi_load),
    .value (TREFI_LOAD),
    .en    (trefi_run),
    .zero  (trefi_zero)
  );

  timing_down_counter #(
    .W       (RW),
    .RST_VAL (TRFC_LOAD)
  ) u_trfc (
    .clk   (clk),
    .rst   (rst),
    .load  (issue_ok),
    .value (TRFC_LOAD),
    .en    (state == S_TRFC),
    .zero  (trfc_zero)
  );

  assign urgent   = (pending >= PEND_URG);
  assign gnt_ok   = bus.ref_gnt && req;
  assign issue_ok = bus.ref_issue && (state == S_GRANT);

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= S_INIT;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    if (!bus.init_done) begin
      state_nxt = S_INIT;
    end else begin
      unique case (state)
        S_INIT:  state_nxt = S_RUN;
        S_RUN:   if (gnt_ok) state_nxt = S_GRANT;
        S_GRANT: if (bus.ref_issue) state_nxt = S_TRFC;
        S_TRFC:  if (trfc_zero) state_nxt = S_RUN;
        default: state_nxt = S_INIT;
      endcase
    end
  end

  always_comb begin
    req  = 1'b0;
    flag = 1'b0;
    busy = 1'b0;
    unique case (state)
      S_RUN:   req  = (pending != '0) && ((&bus.bank_idle) || urgent);
      S_GRANT: flag = 1'b1;
      S_TRFC:  busy = 1'b1;
      default: ;
    endcase
  end

  // Simultaneous tick and accepted issue cancel out, so saturation is not hit.
  always_ff @(posedge clk) begin
    if (rst) begin
      pending    <= '0;
      err_ovf_q  <= 1'b0;
      err_prot_q <= 1'b0;
    end else begin
      if (!bus.init_done) begin
        pending <= '0;
      end else if (tick && !issue_ok) begin
        if (pending == PEND_MAX) begin
          err_ovf_q <= 1'b1;
        end else begin
          pending <= pending + PW'(1);
        end
      end else if (issue_ok && !tick) begin
        if (pending != '0) begin
          pending <= pending - PW'(1);
        end
      end
      if ((bus.ref_gnt && !gnt_ok) || (bus.ref_issue && !issue_ok)) begin
        err_prot_q <= 1'b1;
      end
    end
  end

  assign bus.refresh_flag = flag;
  assign bus.ref_req      = req;
  assign bus.ref_urgent   = urgent;
  assign bus.ref_busy     = busy;
  assign bus.pending_cnt  = pending;
  assign bus.err_overflow = err_ovf_q;
  assign bus.err_protocol = err_prot_q;

endmodule

// File: tb/tb_refresh_scheduler.sv
module tb_refresh_scheduler;

  localparam int unsigned T_REFI = 20;
  localparam int unsigned T_RFC  = 5;
  localparam int unsigned MAXP   = 4;
  localparam int unsigned BANKS  = 8;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  int edge_cnt = 0;
  always @(posedge clk) edge_cnt <= edge_cnt + 1;

  refresh_scheduler_if #(.BANK_NUM(BANKS), .MAX_POSTPONE(MAXP)) bus ();

  refresh_scheduler #(
    .CYCLE_TREFI  (T_REFI),
    .CYCLE_TRFC   (T_RFC),
    .MAX_POSTPONE (MAXP),
    .BANK_NUM     (BANKS)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  typedef enum int {SIG_PEND, SIG_REQ, SIG_URG, SIG_FLAG, SIG_BUSY, SIG_OVF, SIG_PROT} sig_e;
  typedef struct {
    int   cyc;
    sig_e sig;
    int   val;
  } exp_t;

  exp_t q[$];
  int   t0 = 0;
  int   n_checks = 0;
  int   n_pass = 0;
  bit   stim_done = 1'b0;

  function automatic string sig_name(input sig_e s);
    case (s)
      SIG_PEND: return "pending_cnt";
      SIG_REQ:  return "ref_req";
      SIG_URG:  return "ref_urgent";
      SIG_FLAG: return "refresh_flag";
      SIG_BUSY: return "ref_busy";
      SIG_OVF:  return "err_overflow";
      default:  return "err_protocol";
    endcase
  endfunction

  function automatic int actual(input sig_e s);
    case (s)
      SIG_PEND: return int'(bus.pending_cnt);
      SIG_REQ:  return int'(bus.ref_req);
      SIG_URG:  return int'(bus.ref_urgent);
      SIG_FLAG: return int'(bus.refresh_flag);
      SIG_BUSY: return int'(bus.ref_busy);
      SIG_OVF:  return int'(bus.err_overflow);
      default:  return int'(bus.err_protocol);
    endcase
  endfunction

  // Expected value of signal s at cycle t0+rel (kept sorted by cycle)
  task automatic expect_at(input int rel, input sig_e s, input int v);
    exp_t e;
    e.cyc = t0 + rel;
    e.sig = s;
    e.val = v;
    for (int i = 0; i < q.size(); i++) begin
      if (q[i].cyc > e.cyc) begin
        q.insert(i, e);
        return;
      end
    end
    q.push_back(e);
  endtask

  task automatic expect_reset_state(input int rel);
    expect_at(rel, SIG_PEND, 0);
    expect_at(rel, SIG_REQ,  0);
    expect_at(rel, SIG_URG,  0);
    expect_at(rel, SIG_FLAG, 0);
    expect_at(rel, SIG_BUSY, 0);
    expect_at(rel, SIG_OVF,  0);
    expect_at(rel, SIG_PROT, 0);
  endtask

  // Returns just after the posedge that starts cycle t0+rel
  task automatic go(input int rel);
    while (edge_cnt < t0 + rel) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic reset_release();
    rst           = 1'b1;
    bus.init_done = 1'b1;
    bus.bank_idle = 8'hFF;
    bus.ref_gnt   = 1'b0;
    bus.ref_issue = 1'b0;
    repeat (2) begin
      @(posedge clk);
      #1;
    end
    t0 = edge_cnt;
    expect_reset_state(0);
    rst = 1'b0;
  endtask

  // Monitor: compares DUT outputs against the scoreboard every cycle
  initial begin
    exp_t e;
    int   drain;
    int   act;
    drain = 0;
    forever begin
      @(negedge clk);
      while (q.size() != 0 && q[0].cyc <= edge_cnt) begin
        e = q.pop_front();
        n_checks++;
        if (e.cyc < edge_cnt) begin
          $display("FAIL %s missed at cycle %0d: no sample, expected %0d",
                   sig_name(e.sig), e.cyc - t0, e.val);
        end else begin
          act = actual(e.sig);
          if (act == e.val) begin
            n_pass++;
          end else begin
            $display("FAIL %s at cycle %0d: got %0d expected %0d",
                     sig_name(e.sig), e.cyc - t0, act, e.val);
          end
        end
      end
      if (stim_done) begin
        drain++;
        if (q.size() == 0 || drain > 50) begin
          while (q.size() != 0) begin
            e = q.pop_front();
            n_checks++;
            $display("FAIL %s never checked at cycle %0d, expected %0d",
                     sig_name(e.sig), e.cyc - t0, e.val);
          end
          $display("%0d/%0d checks passed", n_pass, n_checks);
          $finish;
        end
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time exceeded, %0d/%0d passed", n_pass, n_checks);
    $fatal(1, "watchdog");
  end

  initial begin
    // ---------------- phase 1: tick timing, grant, postponement, overflow
    reset_release();
    expect_at(19,  SIG_PEND, 0); expect_at(19,  SIG_REQ, 0);
    expect_at(20,  SIG_PEND, 0); expect_at(20,  SIG_REQ, 0);
    expect_at(21,  SIG_PEND, 1); expect_at(21,  SIG_REQ, 1); expect_at(21, SIG_FLAG, 0);
    expect_at(22,  SIG_FLAG, 1);
    expect_at(23,  SIG_FLAG, 1);
    expect_at(24,  SIG_FLAG, 1); expect_at(24,  SIG_PEND, 1); expect_at(24, SIG_BUSY, 0);
    expect_at(25,  SIG_FLAG, 0); expect_at(25,  SIG_BUSY, 1); expect_at(25, SIG_PEND, 0);
    expect_at(29,  SIG_BUSY, 1);
    expect_at(30,  SIG_BUSY, 0); expect_at(30,  SIG_REQ, 0);  expect_at(30, SIG_PEND, 0);
    expect_at(41,  SIG_PEND, 1); expect_at(41,  SIG_REQ, 0);  expect_at(41, SIG_URG, 0);
    expect_at(50,  SIG_PROT, 0);
    expect_at(51,  SIG_PROT, 1); expect_at(51,  SIG_PEND, 1); expect_at(51, SIG_FLAG, 0);
    expect_at(61,  SIG_PEND, 2); expect_at(61,  SIG_REQ, 0);
    expect_at(80,  SIG_PEND, 2); expect_at(80,  SIG_REQ, 0);  expect_at(80, SIG_URG, 0);
    expect_at(81,  SIG_PEND, 3); expect_at(81,  SIG_URG, 1);  expect_at(81, SIG_REQ, 1);
    expect_at(101, SIG_PEND, 4); expect_at(101, SIG_OVF, 0);
    expect_at(120, SIG_PEND, 4); expect_at(120, SIG_OVF, 0);
    expect_at(121, SIG_PEND, 4); expect_at(121, SIG_OVF, 1);

    go(21);  bus.ref_gnt   = 1'b1;
    go(22);  bus.ref_gnt   = 1'b0;
    go(24);  bus.ref_issue = 1'b1;
    go(25);  bus.ref_issue = 1'b0;
    go(30);  bus.bank_idle = 8'hFE;
    go(50);  bus.ref_gnt   = 1'b1;   // stray grant, ref_req is low
    go(51);  bus.ref_gnt   = 1'b0;
    go(122);

    // ---------------- phase 2: tick+issue, stray issue, init drop, reset
    reset_release();
    expect_at(41,  SIG_PEND, 2); expect_at(41,  SIG_REQ, 1);
    expect_at(42,  SIG_FLAG, 1);
    expect_at(60,  SIG_FLAG, 1); expect_at(60,  SIG_PEND, 2);
    expect_at(61,  SIG_PEND, 2); expect_at(61,  SIG_BUSY, 1); expect_at(61, SIG_FLAG, 0);
    expect_at(61,  SIG_OVF,  0); expect_at(61,  SIG_PROT, 0);
    expect_at(65,  SIG_BUSY, 1);
    expect_at(66,  SIG_BUSY, 0); expect_at(66,  SIG_REQ, 1);  expect_at(66, SIG_PEND, 2);
    expect_at(70,  SIG_PROT, 0);
    expect_at(71,  SIG_PROT, 1); expect_at(71,  SIG_PEND, 2);
    expect_at(75,  SIG_PEND, 1); expect_at(75,  SIG_BUSY, 1);
    expect_at(76,  SIG_BUSY, 1);
    expect_at(77,  SIG_BUSY, 0); expect_at(77,  SIG_FLAG, 0); expect_at(77, SIG_REQ, 0);
    expect_at(77,  SIG_URG,  0); expect_at(77,  SIG_PEND, 0); expect_at(77, SIG_PROT, 1);
    expect_at(77,  SIG_OVF,  0);
    expect_at(100, SIG_PEND, 0);
    expect_at(101, SIG_PEND, 1); expect_at(101, SIG_REQ, 1);
    expect_at(102, SIG_FLAG, 1);
    expect_at(103, SIG_FLAG, 1);
    expect_at(104, SIG_FLAG, 0); expect_at(104, SIG_PEND, 0); expect_at(104, SIG_PROT, 0);
    expect_at(104, SIG_REQ,  0); expect_at(104, SIG_BUSY, 0);

    go(41);  bus.ref_gnt   = 1'b1;
    go(42);  bus.ref_gnt   = 1'b0;
    go(60);  bus.ref_issue = 1'b1;   // coincides with the third tick
    go(61);  bus.ref_issue = 1'b0;
    go(70);  bus.ref_issue = 1'b1;   // stray issue in S_RUN
    go(71);  bus.ref_issue = 1'b0;
    go(72);  bus.ref_gnt   = 1'b1;
    go(73);  bus.ref_gnt   = 1'b0;
    go(74);  bus.ref_issue = 1'b1;
    go(75);  bus.ref_issue = 1'b0;
    go(76);  bus.init_done = 1'b0;   // drop during tRFC
    go(80);  bus.init_done = 1'b1;
    go(101); bus.ref_gnt   = 1'b1;
    go(102); bus.ref_gnt   = 1'b0;
    go(103); rst           = 1'b1;   // reset while in S_GRANT
    go(105); rst           = 1'b0;
    stim_done = 1'b1;
  end

endmodule
